// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_types_pkg                                                        |
// | Shared CPU word, RAM handshake and memory arbiter state types.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IGRANT = 2'b01,
      DGRANT = 2'b10
   } arb_state_t;

   // RAM has not finished yet and has not failed: the grant must be held.
   function automatic logic ram_pending(input ramstate_t s);
      return (s == FREE) || (s == BUSY);
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_fair_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_fair_counter                                                     |
// | Saturating count of data grants taken while an instruction waits.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module arb_fair_counter #(
   parameter int STARVE_MAX = 4
) (
   input  logic CLK,
   input  logic nRST,
   input  logic inc,
   input  logic clr,
   output logic starved
);

   localparam int               c_cw        = $clog2(STARVE_MAX + 1);
   localparam logic [c_cw-1:0]  c_count_max = c_cw'(STARVE_MAX);

   logic [c_cw-1:0] r_count;

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != c_count_max)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign starved = (r_count == c_count_max);

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_arbiter                                                       |
// | Shares one RAM port between instruction and data requesters.        |
// | Define MEMORY_ARBITER_FAIRNESS_EN to bound instruction starvation.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate
);

   arb_state_t r_state;
   arb_state_t w_next_state;
   logic       w_dreq;
   logic       w_force_i;

   assign w_dreq = dREN | dWEN;

`ifdef MEMORY_ARBITER_FAIRNESS_EN
   logic w_starved;
   logic w_fair_inc;
   logic w_fair_clr;

   assign w_fair_inc = (r_state == IDLE) && (w_next_state == DGRANT) && iREN;
   assign w_fair_clr = (r_state == IDLE) && ((w_next_state == IGRANT) || !iREN);

   arb_fair_counter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_fair_counter (
      .CLK     (CLK),
      .nRST    (nRST),
      .inc     (w_fair_inc),
      .clr     (w_fair_clr),
      .starved (w_starved)
   );

   assign w_force_i = w_starved && iREN;
`else
   logic [31:0] w_unused_starve_max;

   assign w_unused_starve_max = STARVE_MAX;
   assign w_force_i           = 1'b0;
`endif

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Outputs follow the state and the live requester inputs; nothing is latched.
   always_comb begin
      w_next_state = r_state;
      ramREN       = 1'b0;
      ramWEN       = 1'b0;
      ramaddr      = '0;
      ramstore     = '0;
      iload        = '0;
      dload        = '0;
      iwait        = 1'b1;
      dwait        = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_dreq && !w_force_i) begin
               w_next_state = DGRANT;
            end else if (iREN) begin
               w_next_state = IGRANT;
            end
         end
         IGRANT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            iload   = ramload;
            iwait   = !(iREN && (ramstate == ACCESS));
            if (!(iREN && ram_pending(ramstate))) begin
               w_next_state = IDLE;
            end
         end
         DGRANT: begin
            ramREN   = dREN & ~dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dload    = ramload;
            dwait    = !(w_dreq && (ramstate == ACCESS));
            if (!(w_dreq && ram_pending(ramstate))) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory_arbiter                                                    |
// | Directed scenarios plus random traffic against an ownership model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   localparam int STARVE_MAX = 4;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
   localparam bit c_fair = 1'b1;
`else
   localparam bit c_fair = 1'b0;
`endif

   logic      CLK = 1'b0;
   logic      nRST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   ramstate_t ramstate;
   logic      iwait, dwait, ramREN, ramWEN;
   word_t     iload, dload, ramaddr, ramstore;

   memory_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who currently owns the RAM port, and how long instruction has waited.
   typedef enum {M_NONE, M_INST, M_DATA} owner_e;
   owner_e owner  = M_NONE;
   int     starve = 0;
   wire    m_dreq  = dREN | dWEN;
   wire    m_hold  = (ramstate == FREE) || (ramstate == BUSY);
   wire    m_force = c_fair && iREN && (starve >= STARVE_MAX);

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         owner  <= M_NONE;
         starve <= 0;
      end else if (owner == M_INST) begin
         owner <= (iREN && m_hold) ? M_INST : M_NONE;
      end else if (owner == M_DATA) begin
         owner <= (m_dreq && m_hold) ? M_DATA : M_NONE;
      end else if (m_dreq && !m_force) begin
         owner  <= M_DATA;
         starve <= !iREN ? 0 : (starve < STARVE_MAX ? starve + 1 : STARVE_MAX);
      end else if (iREN) begin
         owner  <= M_INST;
         starve <= 0;
      end else begin
         starve <= 0;
      end
   end

   logic  e_ramREN, e_ramWEN, e_iwait, e_dwait;
   word_t e_ramaddr, e_ramstore, e_iload, e_dload;

   always_comb begin
      e_ramREN = 1'b0; e_ramWEN = 1'b0; e_iwait = 1'b1; e_dwait = 1'b1;
      e_ramaddr = '0; e_ramstore = '0; e_iload = '0; e_dload = '0;
      if (owner == M_INST) begin
         e_ramREN  = iREN;
         e_ramaddr = iaddr;
         e_iload   = ramload;
         e_iwait   = !(iREN && ramstate == ACCESS);
      end else if (owner == M_DATA) begin
         e_ramREN   = dREN && !dWEN;
         e_ramWEN   = dWEN;
         e_ramaddr  = daddr;
         e_ramstore = dstore;
         e_dload    = ramload;
         e_dwait    = !(m_dreq && ramstate == ACCESS);
      end
   end

   // Single per-cycle comparison of every output against the model.
   logic i_done = 1'b0, d_done = 1'b0;
   always @(negedge CLK) begin
      chk("m_ramREN",   ramREN,   e_ramREN);
      chk("m_ramWEN",   ramWEN,   e_ramWEN);
      chk("m_ramaddr",  ramaddr,  e_ramaddr);
      chk("m_ramstore", ramstore, e_ramstore);
      chk("m_iwait",    iwait,    e_iwait);
      chk("m_dwait",    dwait,    e_dwait);
      chk("m_iload",    iload,    e_iload);
      chk("m_dload",    dload,    e_dload);
      i_done <= iREN && !e_iwait;
      d_done <= m_dreq && !e_dwait;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic ramstate_t rand_rs();
      int r = $urandom_range(0, 19);
      if (r < 10)      return ACCESS;
      else if (r < 14) return BUSY;
      else if (r < 17) return FREE;
      else             return ERROR;
   endfunction

   initial begin
      nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1;
      iaddr = 32'h10; daddr = 32'h20; dstore = 32'hFFFF; ramload = 32'h1234;
      ramstate = ACCESS;
      #2;
      chk("rst_ramREN",   ramREN,   1'b0);
      chk("rst_ramWEN",   ramWEN,   1'b0);
      chk("rst_ramaddr",  ramaddr,  32'h0);
      chk("rst_ramstore", ramstore, 32'h0);
      chk("rst_iwait",    iwait,    1'b1);
      chk("rst_dwait",    dwait,    1'b1);
      chk("rst_iload",    iload,    32'h0);
      chk("rst_dload",    dload,    32'h0);
      iREN = 1'b0; dWEN = 1'b0;
      tick();
      nRST = 1'b1;
      tick();

      // Instruction fetch with immediate ACCESS.
      iREN = 1'b1; iaddr = 32'h40; ramload = 32'h8C220004; ramstate = ACCESS;
      #1;
      chk("s1_c1_ramREN", ramREN, 1'b0);
      chk("s1_c1_iwait",  iwait,  1'b1);
      tick(); #1;
      chk("s1_c2_ramREN",  ramREN,  1'b1);
      chk("s1_c2_ramaddr", ramaddr, 32'h40);
      chk("s1_c2_iwait",   iwait,   1'b0);
      chk("s1_c2_iload",   iload,   32'h8C220004);
      chk("s1_model_iload", e_iload, 32'h8C220004);
      tick(); #1;
      chk("s1_c3_ramREN", ramREN, 1'b0);
      chk("s1_c3_iwait",  iwait,  1'b1);
      iREN = 1'b0;
      tick();

      // Simultaneous requests: data first, then instruction.
      iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
      #1;
      chk("s2_idle_dwait", dwait, 1'b1);
      tick(); #1;
      chk("s2_d_ramWEN",   ramWEN,   1'b1);
      chk("s2_d_ramREN",   ramREN,   1'b0);
      chk("s2_d_ramaddr",  ramaddr,  32'h100);
      chk("s2_d_ramstore", ramstore, 32'hDEADBEEF);
      chk("s2_d_dwait",    dwait,    1'b0);
      chk("s2_d_iwait",    iwait,    1'b1);
      chk("s2_model_store", e_ramstore, 32'hDEADBEEF);
      dWEN = 1'b0;
      tick(); #1;
      chk("s2_idle2_ramWEN", ramWEN, 1'b0);
      chk("s2_idle2_iwait",  iwait,  1'b1);
      tick(); #1;
      chk("s2_i_ramREN",  ramREN,  1'b1);
      chk("s2_i_ramaddr", ramaddr, 32'h80);
      chk("s2_i_iwait",   iwait,   1'b0);
      iREN = 1'b0;
      tick();

      // Data read held off by BUSY for three cycles.
      dREN = 1'b1; daddr = 32'h200; ramstate = BUSY; ramload = 32'h12345678;
      tick();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("s3_busy_dwait",  dwait,  1'b1);
         chk("s3_busy_ramREN", ramREN, 1'b1);
         tick();
      end
      ramstate = ACCESS;
      #1;
      chk("s3_acc_dwait", dwait, 1'b0);
      chk("s3_acc_dload", dload, 32'h12345678);
      dREN = 1'b0;
      tick();

      // ERROR during instruction grant retries through IDLE.
      iREN = 1'b1; iaddr = 32'h44; ramstate = ERROR;
      tick(); #1;
      chk("s4_err_ramREN", ramREN, 1'b1);
      chk("s4_err_iwait",  iwait,  1'b1);
      tick(); #1;
      chk("s4_idle_ramREN", ramREN, 1'b0);
      chk("s4_idle_iwait",  iwait,  1'b1);
      ramstate = ACCESS;
      tick(); #1;
      chk("s4_regrant_ramaddr", ramaddr, 32'h44);
      chk("s4_regrant_iwait",   iwait,   1'b0);
      iREN = 1'b0;
      tick();

      // Asynchronous reset in the middle of a data write.
      dWEN = 1'b1; daddr = 32'h300; dstore = 32'h55; ramstate = BUSY;
      tick(); #1;
      chk("s5_pre_ramWEN", ramWEN, 1'b1);
      nRST = 1'b0;
      #1;
      chk("s5_rst_ramWEN",  ramWEN,  1'b0);
      chk("s5_rst_dwait",   dwait,   1'b1);
      chk("s5_rst_ramaddr", ramaddr, 32'h0);
      #3;
      nRST = 1'b1;
      #1;
      chk("s5_rel_ramWEN", ramWEN, 1'b0);
      dWEN = 1'b0;
      tick();

      // Continuous data reads against a waiting instruction fetch.
      dREN = 1'b1; daddr = 32'h400; iREN = 1'b1; iaddr = 32'h48; ramstate = ACCESS;
      for (int g = 1; g <= 5; g++) begin
         tick(); #1;
         chk("s6_grant_addr", ramaddr, (c_fair && g == 5) ? 32'h48 : 32'h400);
         chk("s6_grant_ren",  ramREN,  1'b1);
         tick();
      end
      dREN = 1'b0; iREN = 1'b0;
      tick(); tick(); tick();

      // Random traffic; requesters hold until completion, occasionally withdraw.
      for (int n = 0; n < 3000; n++) begin
         tick();
         if (!iREN || i_done) begin
            iREN  = ($urandom_range(0, 2) != 0);
            iaddr = $urandom;
         end else if ($urandom_range(0, 40) == 0) begin
            iREN = 1'b0;
         end
         if (!(dREN || dWEN) || d_done) begin
            int r = $urandom_range(0, 9);
            dREN   = (r >= 4 && r <= 6) || (r == 9);
            dWEN   = (r >= 7);
            daddr  = $urandom;
            dstore = $urandom;
         end else if ($urandom_range(0, 40) == 0) begin
            dREN = 1'b0; dWEN = 1'b0;
         end
         ramstate = rand_rs();
         ramload  = $urandom;
      end
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive data grants allowed while an instruction request waits.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 iREN  input  1  instruction read request.
REQ-005 iaddr  input  32  instruction address (word_t).
REQ-006 iwait  output  1  instruction not yet complete; low marks the completion cycle.
REQ-007 iload  output  32  instruction read data, valid when iREN=1 and iwait=0.
REQ-008 dREN, dWEN  input  1 each  data read / write request; both high is illegal and is treated as dWEN.
REQ-009 daddr, dstore  input  32 each  data address and data write value.
REQ-010 dwait  output  1  data access not yet complete; low marks the completion cycle.
REQ-011 dload  output  32  data read value, valid when dREN=1 and dwait=0.
REQ-012 ramREN, ramWEN  output  1 each  RAM read and write strobes.
REQ-013 ramaddr, ramstore  output  32 each  RAM address and RAM write data.
REQ-014 ramload  input  32  RAM read data.
REQ-015 ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-016 The FSM SHALL have three states: IDLE, IGRANT and DGRANT.
REQ-017 In IDLE, no RAM strobe is asserted, and iwait=1 and dwait=1 whenever the matching request is high.
REQ-018 IDLE SHALL go to DGRANT when (dREN|dWEN) is set and fairness does not force instruction; else to IGRANT when iREN is set; else stay in IDLE.
REQ-019 In IGRANT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, iload=ramload.
REQ-020 In DGRANT: ramREN=dREN&~dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore, dload=ramload.
REQ-021 The granted requester's wait SHALL drop combinationally in the cycle where ramstate==ACCESS, and the FSM returns to IDLE on the next edge.
REQ-022 The non-granted requester's wait SHALL stay 1 throughout.
REQ-023 The minimum latency is 2 cycles from request to completion: one IDLE cycle plus one grant cycle with an immediate ACCESS.
REQ-024 On BUSY or FREE, the FSM SHALL hold the grant state and the requester's wait stays 1.
REQ-025 On ERROR, the FSM SHALL return to IDLE with wait held at 1, so the access is retried through normal arbitration.
REQ-026 If the granted request is withdrawn mid-grant, the FSM SHALL return to IDLE next edge with no completion, and the RAM strobes drop the same cycle.
REQ-027 A request arriving during the other requester's grant SHALL wait; it is never pre-empted.
REQ-028 Requester inputs are held stable by the requester until its wait goes low; the arbiter does not latch addresses or data.
REQ-029 When ramstore is not in use, it SHALL be driven to 0; iload and dload are driven to 0 outside their own grant.

Reset
REQ-030 Asserting nRST SHALL immediately force: state=IDLE, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0, fairness counter=0.
REQ-031 Reset during a grant SHALL abandon the access with no completion signalled.

Configuration
REQ-032 When MEMORY_ARBITER_FAIRNESS_EN is defined, a counter SHALL increment on each DGRANT entry while iREN=1.
REQ-033 With the macro defined, reaching STARVE_MAX SHALL force the next IDLE decision to IGRANT.
REQ-034 With the macro defined, the counter SHALL clear on IGRANT entry or when iREN=0 in IDLE, and it saturates at STARVE_MAX.
REQ-035 With the macro undefined, there is no counter and data SHALL have strict priority.

Structure
REQ-036 ramstate_t and word_t SHALL come from cpu_types_pkg, and arb_state_t SHALL be added there.
REQ-037 The fairness counter SHALL be the sub-module arb_fair_counter, instantiated only under MEMORY_ARBITER_FAIRNESS_EN.

Verification
REQ-038 Scenario: iREN=1, iaddr=0x40, ramstate=ACCESS, ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 in cycle 2, iwait=0 and iload=0x8C220004 the same cycle, IDLE in cycle 3.
REQ-039 Scenario: iREN and dWEN both set, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first with ramWEN=1 and ramstore=0xDEADBEEF, then after dwait=0, IGRANT.
REQ-040 Scenario: ramstate=BUSY for 3 cycles during DGRANT with dREN -> dwait=1 for those 3 cycles, then 0 in the ACCESS cycle with dload=ramload.
REQ-041 Scenario: ERROR during IGRANT -> IDLE next cycle with iwait=1, and re-grant follows.
REQ-042 Scenario: nRST asserted mid-DGRANT -> ramWEN=0 and dwait=1 with no clock edge, state IDLE after release.
REQ-043 Scenario: with FAIRNESS_EN and STARVE_MAX=4, dREN held continuously and iREN=1 -> after 4 data grants the 5th grant is IGRANT.
